// File: rtl/lockstep_pkg.sv
// Shared types for the lockstep data bridge: FSM states, fault codes and the
// default-width request record compared between the two cores.
package lockstep_pkg;

    localparam int LS_ADDR_W = 32;
    localparam int LS_DATA_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_PEER,
        ISSUE,
        RESP,
        FAULT
    } state_e;

    typedef enum logic [1:0] {
        FC_NONE     = 2'b00,
        FC_MISMATCH = 2'b01,
        FC_SKEW     = 2'b10
    } fault_code_e;

    typedef struct packed {
        logic                   we;
        logic [LS_DATA_W/8-1:0] be;
        logic [LS_ADDR_W-1:0]   addr;
        logic [LS_DATA_W-1:0]   wdata;
    } req_t;

endpackage

// File: rtl/lockstep_req_cmp.sv
// Field-by-field comparison of the two cores' requests; write data only
// takes part when the request is a write.
module lockstep_req_cmp
    import lockstep_pkg::*;
#(
    parameter type cmp_req_t = req_t
) (
    input  cmp_req_t i_req_a,
    input  cmp_req_t i_req_b,
    output logic     o_match
);

    logic w_ctrl_eq;
    logic w_wdata_eq;

    assign w_ctrl_eq  = (i_req_a.we == i_req_b.we) &&
                        (i_req_a.be == i_req_b.be) &&
                        (i_req_a.addr == i_req_b.addr);
    assign w_wdata_eq = (i_req_a.wdata == i_req_b.wdata);
    assign o_match    = w_ctrl_eq && (!i_req_a.we || w_wdata_eq);

endmodule

// File: rtl/lockstep_data_bridge.sv
// Lockstep bridge between a master and a shadow core data port and one memory.
// Build option FAULT_INJECT_EN adds inject_i, which flips b_addr_i[0] before the compare.
module lockstep_data_bridge
    import lockstep_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int SKEW_MAX   = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
`ifdef FAULT_INJECT_EN
    input  logic                    inject_i,
`endif
    input  logic                    a_req_i,
    input  logic                    a_we_i,
    input  logic [DATA_WIDTH/8-1:0] a_be_i,
    input  logic [ADDR_WIDTH-1:0]   a_addr_i,
    input  logic [DATA_WIDTH-1:0]   a_wdata_i,
    input  logic                    b_req_i,
    input  logic                    b_we_i,
    input  logic [DATA_WIDTH/8-1:0] b_be_i,
    input  logic [ADDR_WIDTH-1:0]   b_addr_i,
    input  logic [DATA_WIDTH-1:0]   b_wdata_i,
    output logic                    core_gnt_o,
    output logic                    core_rvalid_o,
    output logic [DATA_WIDTH-1:0]   core_rdata_o,
    output logic                    mem_req_o,
    input  logic                    mem_gnt_i,
    input  logic                    mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
    output logic                    mem_we_o,
    output logic [DATA_WIDTH/8-1:0] mem_be_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    output logic                    fault_o,
    output logic [1:0]              fault_code_o
);

    localparam int BE_W = DATA_WIDTH / 8;
    localparam logic [3:0] SKEW_LIMIT = 4'(SKEW_MAX);

    typedef struct packed {
        logic                  we;
        logic [BE_W-1:0]       be;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } bridge_req_t;

    state_e      r_state,    w_state_nxt;
    logic [3:0]  r_skew_cnt, w_skew_cnt_nxt;
    logic        r_lead_b,   w_lead_b_nxt;
    bridge_req_t r_hold,     w_hold_nxt;
    fault_code_e r_fcode,    w_fcode_nxt;

    bridge_req_t w_req_a;
    bridge_req_t w_req_b;
    logic        w_match;
    logic        w_both_req;
    logic        w_lead_req;

    assign w_req_a = {a_we_i, a_be_i, a_addr_i, a_wdata_i};
`ifdef FAULT_INJECT_EN
    assign w_req_b = {b_we_i, b_be_i, b_addr_i ^ {{(ADDR_WIDTH-1){1'b0}}, inject_i}, b_wdata_i};
`else
    assign w_req_b = {b_we_i, b_be_i, b_addr_i, b_wdata_i};
`endif

    assign w_both_req = a_req_i && b_req_i;
    assign w_lead_req = r_lead_b ? b_req_i : a_req_i;

    lockstep_req_cmp #(
        .cmp_req_t (bridge_req_t)
    ) u_req_cmp (
        .i_req_a (w_req_a),
        .i_req_b (w_req_b),
        .o_match (w_match)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= IDLE;
            r_skew_cnt <= '0;
            r_lead_b   <= 1'b0;
            r_hold     <= '0;
            r_fcode    <= FC_NONE;
        end else begin
            r_state    <= w_state_nxt;
            r_skew_cnt <= w_skew_cnt_nxt;
            r_lead_b   <= w_lead_b_nxt;
            r_hold     <= w_hold_nxt;
            r_fcode    <= w_fcode_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_skew_cnt_nxt = r_skew_cnt;
        w_lead_b_nxt   = r_lead_b;
        w_hold_nxt     = r_hold;
        w_fcode_nxt    = r_fcode;
        core_gnt_o     = 1'b0;
        core_rvalid_o  = 1'b0;
        core_rdata_o   = '0;
        mem_req_o      = 1'b0;
        mem_we_o       = 1'b0;
        mem_be_o       = '0;
        mem_addr_o     = '0;
        mem_wdata_o    = '0;
        fault_o        = 1'b0;
        fault_code_o   = FC_NONE;

        case (r_state)
            IDLE: begin
                w_skew_cnt_nxt = '0;
                if (w_both_req) begin
                    if (w_match) begin
                        w_hold_nxt  = w_req_a;
                        w_state_nxt = ISSUE;
                    end else begin
                        w_fcode_nxt = FC_MISMATCH;
                        w_state_nxt = FAULT;
                    end
                end else if (a_req_i || b_req_i) begin
                    w_lead_b_nxt   = b_req_i;
                    w_skew_cnt_nxt = 4'd1;
                    w_state_nxt    = WAIT_PEER;
                end
            end
            WAIT_PEER: begin
                if (w_both_req) begin
                    if (w_match) begin
                        w_hold_nxt  = w_req_a;
                        w_state_nxt = ISSUE;
                    end else begin
                        w_fcode_nxt = FC_MISMATCH;
                        w_state_nxt = FAULT;
                    end
                end else if (!w_lead_req) begin
                    // a leader withdrawing its request breaks the handshake
                    w_fcode_nxt = FC_MISMATCH;
                    w_state_nxt = FAULT;
                end else if (r_skew_cnt == SKEW_LIMIT) begin
                    w_fcode_nxt = FC_SKEW;
                    w_state_nxt = FAULT;
                end else begin
                    w_skew_cnt_nxt = r_skew_cnt + 4'd1;
                end
            end
            ISSUE: begin
                mem_req_o   = 1'b1;
                mem_we_o    = r_hold.we;
                mem_be_o    = r_hold.be;
                mem_addr_o  = r_hold.addr;
                mem_wdata_o = r_hold.wdata;
                core_gnt_o  = mem_gnt_i;
                if (mem_gnt_i) begin
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                core_rvalid_o = mem_rvalid_i;
                core_rdata_o  = mem_rvalid_i ? mem_rdata_i : '0;
                if (mem_rvalid_i) begin
                    w_state_nxt = IDLE;
                end
            end
            FAULT: begin
                fault_o      = 1'b1;
                fault_code_o = r_fcode;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_lockstep_data_bridge.sv
// Self-checking bench for lockstep_data_bridge: directed table, random transactions
// against a transaction-level model, and hand-written reset/protocol sequences.
module tb_lockstep_data_bridge;

    localparam int SKEW_MAX = 4;

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } treq_t;

    typedef struct {
        string       name;
        int          skew;
        bit          lead_b;
        treq_t       ra;
        treq_t       rb;
        int          gnt_dly;
        int          rv_dly;
        logic [31:0] rdata;
        logic [1:0]  exp_code;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
`ifdef FAULT_INJECT_EN
    logic        inject_i = 1'b0;
`endif
    logic        a_req_i = 1'b0, b_req_i = 1'b0;
    logic        a_we_i = 1'b0, b_we_i = 1'b0;
    logic [3:0]  a_be_i = '0, b_be_i = '0;
    logic [31:0] a_addr_i = '0, b_addr_i = '0;
    logic [31:0] a_wdata_i = '0, b_wdata_i = '0;
    logic        mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;
    logic        core_gnt_o, core_rvalid_o, mem_req_o, mem_we_o, fault_o;
    logic [31:0] core_rdata_o, mem_addr_o, mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic [1:0]  fault_code_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    lockstep_data_bridge #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .SKEW_MAX   (SKEW_MAX)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
`ifdef FAULT_INJECT_EN
        .inject_i      (inject_i),
`endif
        .a_req_i       (a_req_i),
        .a_we_i        (a_we_i),
        .a_be_i        (a_be_i),
        .a_addr_i      (a_addr_i),
        .a_wdata_i     (a_wdata_i),
        .b_req_i       (b_req_i),
        .b_we_i        (b_we_i),
        .b_be_i        (b_be_i),
        .b_addr_i      (b_addr_i),
        .b_wdata_i     (b_wdata_i),
        .core_gnt_o    (core_gnt_o),
        .core_rvalid_o (core_rvalid_o),
        .core_rdata_o  (core_rdata_o),
        .mem_req_o     (mem_req_o),
        .mem_gnt_i     (mem_gnt_i),
        .mem_rvalid_i  (mem_rvalid_i),
        .mem_rdata_i   (mem_rdata_i),
        .mem_we_o      (mem_we_o),
        .mem_be_o      (mem_be_o),
        .mem_addr_o    (mem_addr_o),
        .mem_wdata_o   (mem_wdata_o),
        .fault_o       (fault_o),
        .fault_code_o  (fault_code_o)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic treq_t mkreq(input logic we, input logic [3:0] be,
                                    input logic [31:0] addr, input logic [31:0] wdata);
        treq_t r;
        r.we = we; r.be = be; r.addr = addr; r.wdata = wdata;
        return r;
    endfunction

    function automatic vec_t mkvec(input string name, input int skew, input bit lead_b,
                                   input treq_t ra, input treq_t rb, input int gd, input int rd,
                                   input logic [31:0] rdata, input logic [1:0] code);
        vec_t v;
        v.name = name; v.skew = skew; v.lead_b = lead_b; v.ra = ra; v.rb = rb;
        v.gnt_dly = gd; v.rv_dly = rd; v.rdata = rdata; v.exp_code = code;
        return v;
    endfunction

    // Reference: a late peer beyond the window times out, otherwise the
    // requests must agree (write data only matters on writes).
    function automatic logic [1:0] model_code(input int skew, input treq_t ra, input treq_t rb);
        bit same;
        if (skew > SKEW_MAX) return 2'b10;
        same = (ra.we == rb.we) && (ra.be == rb.be) && (ra.addr == rb.addr) &&
               (!ra.we || ra.wdata == rb.wdata);
        return same ? 2'b00 : 2'b01;
    endfunction

    task automatic idle_inputs();
        a_req_i = 1'b0; b_req_i = 1'b0;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    endtask

    task automatic do_reset(input string tag);
        rst_i = 1'b1;
        @(posedge clk); #1;
        rst_i = 1'b0;
        check({tag, ".rst_ctrl"},
              {59'd0, mem_req_o, core_gnt_o, core_rvalid_o, mem_we_o, fault_o},
              64'd0);
        check({tag, ".rst_code"}, {62'd0, fault_code_o}, 64'd0);
        check({tag, ".rst_bus_nz"},
              {63'd0, |{core_rdata_o, mem_be_o, mem_addr_o, mem_wdata_o}}, 64'd0);
    endtask

    // Called just after a rising edge; leaves inputs idle just after a rising edge.
    task automatic run_txn(input vec_t v);
        int n_mem = 0, n_gnt = 0, n_rv = 0, req_cycles = 0, since_gnt = 0, first_req = -1;
        int end_cyc;
        bit granted = 0, done = 0, gnt_bad = 0, rd_bad = 0;
        logic [31:0] got_rdata = '0;
        treq_t got;
        got = mkreq(1'b0, 4'h0, 32'h0, 32'h0);
        end_cyc = ((v.skew > SKEW_MAX) ? v.skew : SKEW_MAX) + 3;
        for (int cyc = 0; cyc < 60 && !done; cyc++) begin
            a_req_i   = (v.lead_b ? (cyc >= v.skew) : 1'b1) && !granted;
            b_req_i   = (v.lead_b ? 1'b1 : (cyc >= v.skew)) && !granted;
            a_we_i    = v.ra.we; a_be_i = v.ra.be; a_addr_i = v.ra.addr; a_wdata_i = v.ra.wdata;
            b_we_i    = v.rb.we; b_be_i = v.rb.be; b_addr_i = v.rb.addr; b_wdata_i = v.rb.wdata;
            mem_gnt_i    = mem_req_o && (req_cycles == v.gnt_dly);
            mem_rvalid_i = granted && (since_gnt == v.rv_dly);
            mem_rdata_i  = mem_rvalid_i ? v.rdata : $urandom;
            @(negedge clk);
            if (mem_req_o && first_req < 0) first_req = cyc;
            if (mem_req_o && mem_gnt_i) begin
                n_mem++;
                got = mkreq(mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o);
            end
            if (core_gnt_o) n_gnt++;
            if (core_gnt_o !== mem_gnt_i) gnt_bad = 1;
            if (core_rvalid_o) begin
                n_rv++;
                got_rdata = core_rdata_o;
            end else if (core_rdata_o !== 32'h0) begin
                rd_bad = 1;
            end
            if (mem_rvalid_i) done = 1;
            if (v.exp_code != 2'b00 && cyc >= end_cyc) done = 1;
            if (granted) since_gnt++;
            if (mem_req_o) begin
                if (mem_gnt_i) granted = 1;
                req_cycles++;
            end
            @(posedge clk); #1;
        end
        idle_inputs();
        check({v.name, ".finished"}, {63'd0, done}, 64'd1);
        check({v.name, ".rdata_idle0"}, {63'd0, rd_bad}, 64'd0);
        check({v.name, ".gnt_follow"}, {63'd0, gnt_bad}, 64'd0);
        if (v.exp_code == 2'b00) begin
            check({v.name, ".mem_cnt"}, 64'(n_mem), 64'd1);
            check({v.name, ".latency"}, 64'(first_req), 64'(v.skew + 1));
            check({v.name, ".mem_fields"}, {got.we, got.be, got.addr, got.wdata},
                  {v.ra.we, v.ra.be, v.ra.addr, v.ra.wdata});
            check({v.name, ".core_gnt_cnt"}, 64'(n_gnt), 64'd1);
            check({v.name, ".rvalid_cnt"}, 64'(n_rv), 64'd1);
            check({v.name, ".rdata"}, {32'd0, got_rdata}, {32'd0, v.rdata});
            check({v.name, ".no_fault"}, {63'd0, fault_o}, 64'd0);
        end else begin
            check({v.name, ".fault"}, {63'd0, fault_o}, 64'd1);
            check({v.name, ".fault_code"}, {62'd0, fault_code_o}, {62'd0, v.exp_code});
            check({v.name, ".no_mem_req"}, 64'(first_req < 0), 64'd1);
            do_reset(v.name);
        end
    endtask

    vec_t tbl[9];

    initial begin
        tbl[0] = mkvec("rd_sim",   0, 0, mkreq(0, 4'hF, 32'h100, 32'h0), mkreq(0, 4'hF, 32'h100, 32'h0), 1, 1, 32'hDEADBEEF, 2'b00);
        tbl[1] = mkvec("wr_skew3", 3, 0, mkreq(1, 4'hF, 32'h20, 32'h55), mkreq(1, 4'hF, 32'h20, 32'h55), 0, 0, 32'h0, 2'b00);
        tbl[2] = mkvec("skew_to",  5, 0, mkreq(0, 4'hF, 32'h200, 32'h0), mkreq(0, 4'hF, 32'h200, 32'h0), 0, 0, 32'h0, 2'b10);
        tbl[3] = mkvec("wdata_mm", 0, 0, mkreq(1, 4'hF, 32'h30, 32'h11), mkreq(1, 4'hF, 32'h30, 32'h12), 0, 0, 32'h0, 2'b01);
        tbl[4] = mkvec("rd_after", 0, 0, mkreq(0, 4'hF, 32'h104, 32'h0), mkreq(0, 4'hF, 32'h104, 32'h0), 0, 2, 32'h12345678, 2'b00);
        tbl[5] = mkvec("skew4_b",  4, 1, mkreq(1, 4'h3, 32'h3C, 32'hA5A5), mkreq(1, 4'h3, 32'h3C, 32'hA5A5), 2, 0, 32'h0, 2'b00);
        tbl[6] = mkvec("rd_wd_dc", 1, 1, mkreq(0, 4'hF, 32'h80, 32'h1), mkreq(0, 4'hF, 32'h80, 32'h2), 0, 0, 32'h0BADF00D, 2'b00);
        tbl[7] = mkvec("be_mm",    2, 0, mkreq(0, 4'hF, 32'h44, 32'h0), mkreq(0, 4'hE, 32'h44, 32'h0), 0, 0, 32'h0, 2'b01);
        tbl[8] = mkvec("addr_mm",  4, 1, mkreq(0, 4'hF, 32'h10, 32'h0), mkreq(0, 4'hF, 32'h14, 32'h0), 0, 0, 32'h0, 2'b01);

        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        check("reset.ctrl", {59'd0, mem_req_o, core_gnt_o, core_rvalid_o, mem_we_o, fault_o}, 64'd0);
        check("reset.code", {62'd0, fault_code_o}, 64'd0);
        rst_i = 1'b0;

        foreach (tbl[i]) run_txn(tbl[i]);

        // Random transactions checked against the transaction-level model.
        for (int n = 0; n < 40; n++) begin
            vec_t v;
            treq_t ra, rb;
            ra = mkreq(1'($urandom), 4'($urandom), {20'h0, 12'($urandom)}, $urandom);
            rb = ra;
            case ($urandom_range(0, 7))
                0: rb.we    = ~rb.we;
                1: rb.be    = rb.be ^ 4'(1 << $urandom_range(0, 3));
                2: rb.addr  = rb.addr ^ (32'h1 << $urandom_range(0, 11));
                3: rb.wdata = rb.wdata ^ (32'h1 << $urandom_range(0, 31));
                default: ;
            endcase
            v = mkvec($sformatf("rnd%0d", n), int'($urandom_range(0, SKEW_MAX + 2)),
                      1'($urandom), ra, rb, int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)), $urandom, 2'b00);
            v.exp_code = model_code(v.skew, ra, rb);
            run_txn(v);
        end

        // Reset while the memory request is pending drops mem_req_o.
        a_req_i = 1'b1; b_req_i = 1'b1;
        a_we_i = 1'b0; b_we_i = 1'b0; a_be_i = 4'hF; b_be_i = 4'hF;
        a_addr_i = 32'h40; b_addr_i = 32'h40;
        @(posedge clk); #1;
        check("rst_issue.req_before", {63'd0, mem_req_o}, 64'd1);
        rst_i = 1'b1; a_req_i = 1'b0; b_req_i = 1'b0;
        @(posedge clk); #1;
        rst_i = 1'b0;
        check("rst_issue.req_after", {63'd0, mem_req_o}, 64'd0);

        // Reset in RESP: the late memory response must not reach the cores.
        a_req_i = 1'b1; b_req_i = 1'b1;
        @(posedge clk); #1;
        a_req_i = 1'b0; b_req_i = 1'b0;
        mem_gnt_i = 1'b1;
        @(negedge clk);
        check("rst_resp.gnt", {63'd0, core_gnt_o}, 64'd1);
        @(posedge clk); #1;
        mem_gnt_i = 1'b0; rst_i = 1'b1;
        @(posedge clk); #1;
        rst_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hCAFEF00D;
        @(negedge clk);
        check("rst_resp.late_rvalid", {63'd0, core_rvalid_o}, 64'd0);
        check("rst_resp.late_rdata", {32'd0, core_rdata_o}, 64'd0);
        @(posedge clk); #1;
        idle_inputs();

        // Leader withdraws its request before the peer arrives.
        a_req_i = 1'b1;
        @(posedge clk); #1;
        a_req_i = 1'b0;
        @(posedge clk); #1;
        check("lead_drop.fault", {63'd0, fault_o}, 64'd1);
        check("lead_drop.code", {62'd0, fault_code_o}, 64'd1);
        a_req_i = 1'b1; b_req_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("fault_sticky.code", {62'd0, fault_code_o}, 64'd1);
        check("fault_sticky.no_req", {62'd0, mem_req_o, core_gnt_o}, 64'd0);
        idle_inputs();
        do_reset("lead_drop");

`ifdef FAULT_INJECT_EN
        inject_i = 1'b1;
        run_txn(mkvec("inject", 0, 0, mkreq(0, 4'hF, 32'h100, 32'h0),
                      mkreq(0, 4'hF, 32'h100, 32'h0), 0, 0, 32'h0, 2'b01));
        inject_i = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/lockstep_data_bridge.md
Name: lockstep_data_bridge

Overview:
- Sits between the data ports of two lockstep zeroriscy cores (A = master, B = shadow) and the single-port data RAM. It uses the same req/gnt/rvalid protocol on both sides.
- Waits until both cores present a request, with a bounded skew window, and compares the requests field by field.
- On a match, issues exactly one memory access and broadcasts grant and response to both cores.
- On a mismatch or skew timeout, enters a sticky fault state.

Parameters:
- ADDR_WIDTH, 32, address width on core and memory ports
- DATA_WIDTH, 32, data width; byte-enable width is DATA_WIDTH/8
- SKEW_MAX, 4, maximum cycles one core may lead the other before a fault is declared (range 1..15)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- a_req_i / b_req_i  in  1  core request
- a_we_i / b_we_i  in  1  write enable
- a_be_i / b_be_i  in  DATA_WIDTH/8  byte enables
- a_addr_i / b_addr_i  in  ADDR_WIDTH  address
- a_wdata_i / b_wdata_i  in  DATA_WIDTH  write data
- core_gnt_o  out  1  grant, broadcast to both cores
- core_rvalid_o  out  1  response valid, broadcast
- core_rdata_o  out  DATA_WIDTH  read data, broadcast
- mem_req_o  out  1  memory request
- mem_gnt_i  in  1  memory grant
- mem_rvalid_i  in  1  memory response valid
- mem_we_o  out  1  write enable
- mem_be_o  out  DATA_WIDTH/8  byte enables
- mem_addr_o  out  ADDR_WIDTH  address
- mem_wdata_o  out  DATA_WIDTH  write data
- fault_o  out  1  sticky lockstep fault
- fault_code_o  out  2  00 none, 01 mismatch, 10 skew timeout

Behaviour:
- Reset: one clock and one synchronous active-high reset, rst_i, sampled on the rising edge of clk_i. Reset forces state IDLE, skew counter 0, and all outputs 0 from the next edge.
- Reset mid-operation drops mem_req_o. Any memory rvalid arriving after reset is ignored, because IDLE ignores mem_rvalid_i.
- Requests match when we, be and addr are equal; wdata is compared only when we=1.
- IDLE:
  - both req, match: latch A's fields into the holding register, go to ISSUE.
  - both req, mismatch: go to FAULT with code 01.
  - exactly one req: go to WAIT_PEER with counter=1.
  - no req: stay in IDLE.
- WAIT_PEER:
  - both req: compare as in IDLE.
  - otherwise, if counter==SKEW_MAX: go to FAULT with code 10.
  - otherwise: counter+1.
  - If the leading core drops req, that is a protocol violation and is treated as a mismatch (code 01).
- ISSUE:
  - mem_req_o=1, with mem_* driven from the holding register only; the fields are stable until grant.
  - core_gnt_o = mem_gnt_i, combinationally, for one cycle.
  - On mem_gnt_i, go to RESP.
  - Core fields are not re-sampled in ISSUE.
- RESP:
  - mem_req_o=0.
  - On mem_rvalid_i: core_rvalid_o=1 and core_rdata_o=mem_rdata_i in the same cycle, then go to IDLE.
  - Core requests in RESP are ignored and not granted.
- Latency: a matched, simultaneous request reaches mem_req_o 1 cycle after capture. The core sees its grant in the same cycle as the memory grant.
- core_rdata_o is 0 whenever core_rvalid_o=0.
- mem_rvalid_i outside RESP is ignored.
- FAULT:
  - Terminal until rst_i.
  - fault_o=1 and fault_code_o holds the code; no grants, no memory requests.
- SKEW_MAX=1 means the peer must arrive on the very next cycle.

Optional Feature:
- FAULT_INJECT_EN defined: adds input inject_i (1 bit). While inject_i=1, bit 0 of b_addr_i is inverted before comparison, which forces a mismatch for verification.
- Without the macro: no port and no logic; the comparison uses raw inputs.

Decomposition:
- Package lockstep_pkg: state enum (IDLE, WAIT_PEER, ISSUE, RESP, FAULT), fault-code enum, and the request struct typedef {we, be, addr, wdata}.
- Sub-module lockstep_req_cmp: combinational comparison of two request structs; output match.

Test Plan:
- Both cores request a read of addr 0x100 in the same cycle. Required: mem_req_o=1 on the next cycle with addr 0x100; mem_gnt_i pulses core_gnt_o; rvalid with 0xDEADBEEF gives core_rvalid_o=1 and core_rdata_o=0xDEADBEEF; fault_o=0.
- Core A writes 0x55 to 0x20 and core B follows 3 cycles later with the same write (SKEW_MAX=4). Required: exactly one memory write, wdata 0x55, be 0xF.
- Core A requests and core B stays idle for 5 cycles (SKEW_MAX=4). Required: fault_o=1, fault_code_o=10, mem_req_o never asserted.
- A writes 0x11 and B writes 0x12 to the same address. Required: fault_code_o=01 and no memory access. Then rst_i is held for 1 cycle, after which all outputs are 0 and a matched access succeeds.
- rst_i is asserted while in RESP. Required: the late mem_rvalid_i produces no core_rvalid_o.
- (With FAULT_INJECT_EN) inject_i=1 during identical requests. Required: fault_code_o=01.
